// File: rtl/vram_arbiter.sv
// Shares the 4096x8 character buffer RAM between CPU MMIO and VGA scan-out.
// Latency: grant is combinational, read data returns 2 cycles after the grant.
// Backpressure: a requester holds req until its gnt; scan-out wins, CPU gets a slot within MAX_STREAK.
//
// Ports:
//   clock, reset                     system clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_gnt CPU MMIO request and same-cycle accept
//   cpu_rvalid, cpu_rdata            CPU read response (pulse + held data)
//   vga_req/addr -> vga_gnt          scan-out fetch request and same-cycle accept
//   vga_rvalid, vga_rdata            scan-out read response (pulse + held data)
//   ram_en/we/addr/wdata, ram_rdata  single-port RAM interface, rdata one cycle after ram_en
//   stall_clr, stall_cnt             saturating count of cycles the CPU waited
module vram_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 8,
   parameter int MAX_STREAK = 4,
   parameter int STALL_W    = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              stall_clr,
   output logic [STALL_W-1:0] stall_cnt
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

   // Consecutive VGA grants taken while the CPU was waiting.
   logic [3:0] streak;
   logic       streak_full;

   // Response tag for the read issued last cycle; ram_rdata belongs to it now.
   logic tag_vld;
   logic tag_cpu;

   assign streak_full = (streak == STREAK_MAX);

   // Scan-out wins unless the CPU has already yielded MAX_STREAK slots in a row.
   always_comb begin
      cpu_gnt = 1'b0;
      vga_gnt = 1'b0;
      if (!reset) begin
         if (cpu_req && (!vga_req || streak_full)) begin
            cpu_gnt = 1'b1;
         end else if (vga_req) begin
            vga_gnt = 1'b1;
         end
      end
   end

   assign ram_en    = cpu_gnt | vga_gnt;
   assign ram_we    = cpu_gnt & cpu_we;
   assign ram_wdata = cpu_wdata;

   always_comb begin
      ram_addr = '0;
      if (cpu_gnt) begin
         ram_addr = cpu_addr;
      end else if (vga_gnt) begin
         ram_addr = vga_addr;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         streak     <= 4'd0;
         tag_vld    <= 1'b0;
         tag_cpu    <= 1'b0;
         cpu_rvalid <= 1'b0;
         vga_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         vga_rdata  <= '0;
         stall_cnt  <= '0;
      end else begin
         // A CPU grant or a withdrawn CPU request ends the streak.
         if (cpu_gnt || !cpu_req) begin
            streak <= 4'd0;
         end else if (vga_gnt && !streak_full) begin
            streak <= streak + 4'd1;
         end

         // Writes produce no response, so only reads enter the pipeline.
         tag_vld <= ram_en & ~ram_we;
         tag_cpu <= cpu_gnt;

         cpu_rvalid <= tag_vld & tag_cpu;
         vga_rvalid <= tag_vld & ~tag_cpu;
         if (tag_vld && tag_cpu) begin
            cpu_rdata <= ram_rdata;
         end
         if (tag_vld && !tag_cpu) begin
            vga_rdata <= ram_rdata;
         end

         if (stall_clr) begin
            stall_cnt <= '0;
         end else if (cpu_req && !cpu_gnt && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: per-cycle vector table with a response scoreboard.
// Latency: read responses are expected 2 cycles after the expected grant.
// Backpressure: requesters hold req until the grant the table predicts.
module tb_vram_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, vga_req, stall_clr;
   logic [11:0] cpu_addr, vga_addr, ram_addr;
   logic [7:0]  cpu_wdata, cpu_rdata, vga_rdata, ram_wdata;
   logic [7:0]  ram_rdata = 8'h00;
   logic        cpu_gnt, cpu_rvalid, vga_gnt, vga_rvalid, ram_en, ram_we;
   logic [15:0] stall_cnt;

   // Second instance: small stall counter and long streak for saturation.
   logic        s_cpu_req, s_vga_req, s_stall_clr;
   logic        s_cpu_gnt, s_cpu_rvalid, s_vga_gnt, s_vga_rvalid, s_ram_en, s_ram_we;
   logic [7:0]  s_cpu_rdata, s_vga_rdata, s_ram_wdata;
   logic [7:0]  s_ram_rdata = 8'h00;
   logic [11:0] s_ram_addr;
   logic [3:0]  s_stall_cnt;

   always #5 clock = ~clock;

   vram_arbiter dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
      .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .stall_clr(stall_clr), .stall_cnt(stall_cnt)
   );

   vram_arbiter #(.MAX_STREAK(15), .STALL_W(4)) dut_sat (
      .clock(clock), .reset(reset),
      .cpu_req(s_cpu_req), .cpu_we(1'b0), .cpu_addr(12'h000), .cpu_wdata(8'h00),
      .cpu_gnt(s_cpu_gnt), .cpu_rvalid(s_cpu_rvalid), .cpu_rdata(s_cpu_rdata),
      .vga_req(s_vga_req), .vga_addr(12'h000), .vga_gnt(s_vga_gnt),
      .vga_rvalid(s_vga_rvalid), .vga_rdata(s_vga_rdata),
      .ram_en(s_ram_en), .ram_we(s_ram_we), .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata),
      .ram_rdata(s_ram_rdata), .stall_clr(s_stall_clr), .stall_cnt(s_stall_cnt)
   );

   // Behavioural single-port RAM: read data one cycle after ram_en.
   logic [7:0] mem [0:4095];
   always @(posedge clock) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr];
      end
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic        rst, creq, cwe;
      logic [11:0] caddr;
      logic [7:0]  cwd;
      logic        vreq;
      logic [11:0] vaddr;
      logic        clr, egc, egv;
      string       nm;
   } vec_t;

   typedef struct {
      int         due;
      logic       cpu;
      logic [7:0] dat;
   } rsp_t;

   vec_t        vecs[$];
   rsp_t        sbq[$];
   logic [7:0]  ref_mem [0:4095];
   logic [7:0]  last_c = 8'h00, last_v = 8'h00;
   logic [15:0] exp_stall = 16'h0000;
   int          n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic void row(input int rst, input int creq, input int cwe, input int caddr,
                               input int cwd, input int vreq, input int vaddr, input int clr,
                               input int egc, input int egv, input string nm);
      vec_t v;
      v.rst = 1'(rst);  v.creq = 1'(creq); v.cwe = 1'(cwe);
      v.caddr = 12'(caddr); v.cwd = 8'(cwd);
      v.vreq = 1'(vreq); v.vaddr = 12'(vaddr);
      v.clr = 1'(clr); v.egc = 1'(egc); v.egv = 1'(egv); v.nm = nm;
      vecs.push_back(v);
   endfunction

   task automatic check_resp(input string nm);
      logic e_cv = 1'b0;
      logic e_vv = 1'b0;
      rsp_t r;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         r = sbq.pop_front();
         if (r.cpu) begin e_cv = 1'b1; last_c = r.dat; end
         else       begin e_vv = 1'b1; last_v = r.dat; end
      end
      chk({nm, "/cpu_rvalid"}, 32'(cpu_rvalid), 32'(e_cv));
      chk({nm, "/vga_rvalid"}, 32'(vga_rvalid), 32'(e_vv));
      chk({nm, "/cpu_rdata"},  32'(cpu_rdata),  32'(last_c));
      chk({nm, "/vga_rdata"},  32'(vga_rdata),  32'(last_v));
      chk({nm, "/stall_cnt"},  32'(stall_cnt),  32'(exp_stall));
   endtask

   task automatic run_row(input vec_t v);
      logic [11:0] e_addr;
      reset = v.rst; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr;
      cpu_wdata = v.cwd; vga_req = v.vreq; vga_addr = v.vaddr; stall_clr = v.clr;
      #4;
      e_addr = v.egc ? v.caddr : (v.egv ? v.vaddr : 12'h000);
      chk({v.nm, "/cpu_gnt"},  32'(cpu_gnt),  32'(v.egc));
      chk({v.nm, "/vga_gnt"},  32'(vga_gnt),  32'(v.egv));
      chk({v.nm, "/ram_en"},   32'(ram_en),   32'(v.egc | v.egv));
      chk({v.nm, "/ram_we"},   32'(ram_we),   32'(v.egc & v.cwe));
      chk({v.nm, "/ram_addr"}, 32'(ram_addr), 32'(e_addr));
      if (v.egc && v.cwe) chk({v.nm, "/ram_wdata"}, 32'(ram_wdata), 32'(v.cwd));
      check_resp(v.nm);
      if (v.rst) begin
         sbq.delete();
         last_c = 8'h00; last_v = 8'h00; exp_stall = 16'h0000;
      end else begin
         if (v.egc) begin
            if (v.cwe) ref_mem[v.caddr] = v.cwd;
            else sbq.push_back('{due: cyc + 2, cpu: 1'b1, dat: ref_mem[v.caddr]});
         end
         if (v.egv) sbq.push_back('{due: cyc + 2, cpu: 1'b0, dat: ref_mem[v.vaddr]});
         if (v.clr) exp_stall = 16'h0000;
         else if (v.creq && !v.egc && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      end
      @(posedge clock); #1;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i] = 8'(i * 7 + 3);
         ref_mem[i] = 8'(i * 7 + 3);
      end

      // Vector table: rst creq cwe caddr cwd vreq vaddr clr | exp cpu_gnt vga_gnt
      row(0,0,0,0,0,0,0,0,0,0,"idle");
      row(0,1,1,'h010,'h41,0,0,0,1,0,"cpu_wr");
      row(0,1,0,'h010,0,0,0,0,1,0,"cpu_rd");
      row(0,0,0,0,0,0,0,0,0,0,"idle");
      row(0,0,0,0,0,0,0,0,0,0,"idle");
      for (int i = 0; i < 8; i++) row(0,0,0,0,0,1,i,0,0,1,"vga_seq");
      for (int i = 0; i < 3; i++) row(0,0,0,0,0,0,0,0,0,0,"idle");
      for (int k = 0; k < 12; k++)
         row(0,1,0,'h020 + k / 5,0,1,'h100 + k,(k == 10) ? 1 : 0,
             (k % 5 == 4) ? 1 : 0,(k % 5 == 4) ? 0 : 1,"contend");
      row(0,0,0,0,0,0,0,0,0,0,"idle");
      row(0,1,0,'h030,0,1,'h200,0,0,1,"cancel_a");
      row(0,1,0,'h030,0,1,'h201,0,0,1,"cancel_b");
      row(0,0,0,0,0,1,'h202,0,0,1,"cancel_drop");
      for (int k = 0; k < 4; k++) row(0,1,0,'h031,0,1,'h203 + k,0,0,1,"restreak");
      row(0,1,0,'h031,0,1,'h207,0,1,0,"restreak_c");
      row(0,0,0,0,0,0,0,0,0,0,"idle");
      row(0,0,0,0,0,1,'h005,0,0,1,"mix_v1");
      row(0,1,0,'h010,0,0,0,0,1,0,"mix_c");
      row(0,0,0,0,0,1,'h006,0,0,1,"mix_v2");
      for (int i = 0; i < 3; i++) row(0,0,0,0,0,0,0,0,0,0,"idle");
      row(0,1,1,'h007,'hA5,0,0,0,1,0,"raw_wr");
      row(0,0,0,0,0,1,'h007,0,0,1,"raw_rd");
      for (int i = 0; i < 3; i++) row(0,0,0,0,0,0,0,0,0,0,"idle");
      row(0,1,1,'h040,'h00,1,'h300,0,0,1,"pre_stall");
      row(0,1,0,'h010,0,0,0,0,1,0,"flight_rd");
      row(1,0,0,0,0,0,0,0,0,0,"flight_rst");
      for (int i = 0; i < 3; i++) row(0,0,0,0,0,0,0,0,0,0,"post_rst");
      row(0,1,0,'h050,0,1,'h400,0,0,1,"sr_a");
      row(0,1,0,'h050,0,1,'h401,0,0,1,"sr_b");
      row(1,1,0,'h050,0,1,'h402,0,0,0,"sr_rst");
      for (int k = 0; k < 4; k++) row(0,1,0,'h050,0,1,'h402 + k,0,0,1,"sr_after");
      row(0,1,0,'h050,0,1,'h406,0,1,0,"sr_after_c");
      for (int i = 0; i < 3; i++) row(0,0,0,0,0,0,0,0,0,0,"idle");

      // Reset with both requesters asking: no grants, no RAM access.
      reset = 1'b1; cpu_req = 1'b1; vga_req = 1'b1; cpu_we = 1'b0;
      cpu_addr = 12'h000; cpu_wdata = 8'h00; vga_addr = 12'h000; stall_clr = 1'b0;
      s_cpu_req = 1'b0; s_vga_req = 1'b0; s_stall_clr = 1'b0;
      @(posedge clock); #5;
      chk("rst/cpu_gnt", 32'(cpu_gnt), 32'd0);
      chk("rst/vga_gnt", 32'(vga_gnt), 32'd0);
      chk("rst/ram_en",  32'(ram_en),  32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      foreach (vecs[i]) run_row(vecs[i]);
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      // Saturation: 15 stalled cycles reach all-ones, CPU slot, then it must stay at 15.
      s_cpu_req = 1'b1; s_vga_req = 1'b1;
      repeat (14) @(posedge clock);
      #1;
      chk("sat/count14", 32'(s_stall_cnt), 32'd14);
      repeat (30) @(posedge clock);
      #1;
      chk("sat/hold15", 32'(s_stall_cnt), 32'd15);
      s_stall_clr = 1'b1;
      @(posedge clock); #1;
      chk("sat/clr", 32'(s_stall_cnt), 32'd0);
      s_stall_clr = 1'b0; s_cpu_req = 1'b0; s_vga_req = 1'b0;
      @(posedge clock); #1;

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
